// File: rtl/keccak_slice_permuter.sv
// ============================================================================
// Module   : keccak_slice_permuter
// Purpose  : Slice-serial Keccak rho/pi engine: buffers DEPTH 25-bit slices,
//            then streams out the permuted state one slice per cycle.
//            Optional inverse transform enabled by macro PERMUTE_INVERSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_slice_permuter #(
  parameter int DEPTH   = 64,
  parameter bit REG_OUT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
`ifdef PERMUTE_INVERSE_EN
  input  logic        inv,
`endif
  input  logic [24:0] in,
  input  logic        hold,
  output logic        read,
  output logic [24:0] out,
  output logic        ready,
  output logic        totalReady
);

  localparam int c_cw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_slots = 1 << c_cw;
  localparam logic [c_cw-1:0] c_last = c_cw'(DEPTH - 1);
  localparam logic [c_cw-1:0] c_mask = c_cw'(DEPTH - 1);
  // Rotation offsets indexed by lane i = 5*y + x
  localparam int c_rho [25] = '{ 0,  1, 62, 28, 27,
                                36, 44,  6, 55, 20,
                                 3, 10, 43, 25, 39,
                                41, 45, 15, 21,  8,
                                18,  2, 61, 56, 14};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [c_cw-1:0]   r_cnt;
  logic [1:0]        r_mode;
  logic              w_inv;
  logic [24:0]       r_buf [c_slots];
  logic [24:0]       w_perm;
  logic              w_read, w_ready, w_total;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_read  = 1'b0;
    w_ready = 1'b0;
    w_total = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        w_read = 1'b1;
        if (r_cnt == c_last) w_next = S_OUT;
      end
      S_OUT: begin
        w_ready = 1'b1;
        w_total = (r_cnt == c_last);
        if (!hold && r_cnt == c_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_mode <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) r_mode <= mode;
        end
        S_LOAD:  r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        S_OUT:   if (!hold) r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

`ifdef PERMUTE_INVERSE_EN
  logic r_inv;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_inv <= 1'b0;
    else if (r_state == S_IDLE && start) r_inv <= inv;
  end
  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_slots; i++) r_buf[i] <= '0;
    end else if (r_state == S_LOAD) begin
      r_buf[r_cnt] <= in;
    end
  end

  // Each output lane reads one source lane at a rotated slice index.
  // Negative rotations are stored as (64*DEPTH - r), which is -r mod DEPTH.
  for (genvar l = 0; l < 25; l++) begin : g_lane
    localparam int c_x     = l % 5;
    localparam int c_y     = l / 5;
    localparam int c_pisrc = 5 * c_x + (c_x + 3 * c_y) % 5;
    localparam int c_pinv  = 5 * ((2 * (c_x - c_y + 5)) % 5) + c_y;
    localparam logic [c_cw-1:0] c_fwd_self = c_cw'(64 * DEPTH - c_rho[l]);
    localparam logic [c_cw-1:0] c_fwd_pi   = c_cw'(64 * DEPTH - c_rho[c_pisrc]);
    localparam logic [c_cw-1:0] c_bwd_self = c_cw'(c_rho[l]);

    logic [4:0]      w_src;
    logic [c_cw-1:0] w_off;
    logic [c_cw-1:0] w_idx;

    always_comb begin
      w_src = 5'(l);
      w_off = '0;
      if (r_mode[1]) w_src = w_inv ? 5'(c_pinv) : 5'(c_pisrc);
      if (r_mode[0]) begin
        if (w_inv) w_off = c_bwd_self;
        else       w_off = r_mode[1] ? c_fwd_pi : c_fwd_self;
      end
      w_idx = (r_cnt + w_off) & c_mask;
    end

    assign w_perm[l] = r_buf[w_idx][w_src];
  end

  assign read = w_read;

  if (REG_OUT) begin : g_reg_out
    logic [24:0] r_out;
    logic        r_ready;
    logic        r_total;
    // A presented slice stays frozen while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_out   <= '0;
        r_ready <= 1'b0;
        r_total <= 1'b0;
      end else if (!(hold && r_ready)) begin
        r_out   <= w_ready ? w_perm : 25'h0;
        r_ready <= w_ready;
        r_total <= w_total;
      end
    end
    assign out        = r_out;
    assign ready      = r_ready;
    assign totalReady = r_total;
  end else begin : g_comb_out
    assign out        = w_ready ? w_perm : 25'h0;
    assign ready      = w_ready;
    assign totalReady = w_total;
  end

endmodule

`default_nettype wire

// File: tb/tb_keccak_slice_permuter.sv
// ============================================================================
// Module   : tb_keccak_slice_permuter
// Purpose  : Directed self-checking bench for keccak_slice_permuter (DEPTH=64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keccak_slice_permuter;
  localparam int D = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [24:0] in_s = '0;
  logic        read, ready, total;
  logic [24:0] out_s;
`ifdef PERMUTE_INVERSE_EN
  logic        inv = 1'b0;
`endif

  keccak_slice_permuter #(.DEPTH(D), .REG_OUT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
`ifdef PERMUTE_INVERSE_EN
    .inv        (inv),
`endif
    .in         (in_s),
    .hold       (hold),
    .read       (read),
    .out        (out_s),
    .ready      (ready),
    .totalReady (total)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [24:0] slices [D];
  logic [24:0] got    [D];
  logic [1:0]  tb_mode = 2'b00;
  bit          tb_inv = 1'b0;
  int          tb_z = 0;
  // rotation offsets as [y][x]
  int rho_t [5][5] = '{'{ 0,  1, 62, 28, 27},
                       '{36, 44,  6, 55, 20},
                       '{ 3, 10, 43, 25, 39},
                       '{41, 45, 15, 21,  8},
                       '{18,  2, 61, 56, 14}};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected output slice z straight from the lane/rotation rules
  function automatic logic [24:0] model(input int z);
    logic [24:0] r;
    int sx, sy, zs;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        sx = tb_mode[1] ? (x + 3 * y) % 5 : x;
        sy = tb_mode[1] ? x : y;
        zs = tb_mode[0] ? (((z - rho_t[sy][sx]) % D) + D) % D : z;
        r[5 * y + x] = slices[zs][5 * sy + sx];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!ready)     tb_z <= 0;
    else if (!hold) tb_z <= tb_z + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (ready) begin
        if (tb_z < D) begin
          got[tb_z] <= out_s;
          if (!tb_inv) begin
            chk("out_slice", out_s, model(tb_z));
            chk("total_flag", total, tb_z == D - 1);
          end
        end else begin
          chk("ready_overrun", tb_z, D - 1);
        end
      end else begin
        chk("idle_out", out_s, 32'h0);
        chk("idle_total", total, 32'h0);
      end
    end
  end

  task automatic run(input logic [1:0] m, input int hold_z, input int hold_n, input bit poke,
                     output int nread, output int nrdy, output int ntot);
    int hc;
    bit done;
    hc = 0; done = 1'b0; nread = 0; nrdy = 0; ntot = 0;
    tb_mode = m;
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    for (int c = 0; c < 400 && !done; c++) begin
      start = 1'b0;
      hold = 1'b0;
      if (read) begin
        if (nread < D) in_s = slices[nread];
        nread++;
      end
      if (ready) begin
        nrdy++;
        if (total) ntot++;
        if (tb_z == hold_z && hc < hold_n) begin
          hold = 1'b1;
          hc++;
        end
        if (poke && (tb_z == 20 || total)) start = 1'b1;
        if (total && !hold) done = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    hold = 1'b0;
    chk("run_complete", done, 32'h1);
  endtask

  int nr, ny, nt, idle_reads;
  logic [24:0] orig [D];

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_read", read, 32'h0);
    chk("rst_ready", ready, 32'h0);
    chk("rst_total", total, 32'h0);
    chk("rst_out", out_s, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // identity: walking bit
    for (int z = 0; z < D; z++) slices[z] = 25'h1 << (z % 25);
    run(2'b00, -1, 0, 1'b0, nr, ny, nt);
    chk("t1_reads", nr, D);
    chk("t1_ready_cycles", ny, D);
    chk("t1_total_cycles", nt, 1);
    chk("t1_slice30", got[30], 32'h20);
    chk("t1_slice63", got[63], 32'h2000);

    // pi only
    for (int z = 0; z < D; z++) slices[z] = 25'h2;
    run(2'b10, -1, 0, 1'b0, nr, ny, nt);
    chk("t2_slice0", got[0], 32'h400);
    chk("t2_slice63", got[63], 32'h400);

    // rho only: lanes (1,0) r=1 and (0,1) r=36
    for (int z = 0; z < D; z++) slices[z] = 25'h0;
    slices[0] = 25'h22;
    run(2'b01, -1, 0, 1'b0, nr, ny, nt);
    chk("t3_slice0", got[0], 32'h0);
    chk("t3_slice1", got[1], 32'h2);
    chk("t3_slice36", got[36], 32'h20);
    chk("t3_slice37", got[37], 32'h0);

    // rho then pi
    for (int z = 0; z < D; z++) slices[z] = 25'h0;
    slices[0] = 25'h2;
    run(2'b11, -1, 0, 1'b0, nr, ny, nt);
    chk("t4_slice0", got[0], 32'h0);
    chk("t4_slice1", got[1], 32'h400);

    // hold at z=10 for 3 cycles, start poked mid-OUT and on the exit cycle
    for (int z = 0; z < D; z++) slices[z] = 25'($urandom);
    run(2'b11, 10, 3, 1'b1, nr, ny, nt);
    chk("t5_reads", nr, D);
    chk("t5_ready_cycles", ny, D + 3);
    chk("t5_total_cycles", nt, 1);
    idle_reads = 0;
    for (int c = 0; c < 5; c++) begin
      if (read) idle_reads++;
      @(negedge clk);
    end
    chk("t5_no_restart", idle_reads, 0);

    // reset in the middle of LOAD
    for (int z = 0; z < D; z++) slices[z] = 25'($urandom);
    tb_mode = 2'b00;
    mode = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nr = 0;
    for (int c = 0; c < 100 && nr < 20; c++) begin
      if (read) begin
        in_s = slices[nr];
        nr++;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("t6_read", read, 32'h0);
    chk("t6_ready", ready, 32'h0);
    chk("t6_total", total, 32'h0);
    chk("t6_out", out_s, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_idle_read", read, 32'h0);
    for (int z = 0; z < D; z++) slices[z] = 25'($urandom);
    run(2'b00, -1, 0, 1'b0, nr, ny, nt);
    chk("t6_reads", nr, D);
    chk("t6_ready_cycles", ny, D);

`ifdef PERMUTE_INVERSE_EN
    // forward then inverse must restore the state
    for (int z = 0; z < D; z++) begin
      slices[z] = 25'($urandom);
      orig[z] = slices[z];
    end
    run(2'b11, -1, 0, 1'b0, nr, ny, nt);
    @(negedge clk);
    for (int z = 0; z < D; z++) slices[z] = got[z];
    tb_inv = 1'b1;
    inv = 1'b1;
    run(2'b11, -1, 0, 1'b0, nr, ny, nt);
    @(negedge clk);
    inv = 1'b0;
    tb_inv = 1'b0;
    for (int z = 0; z < D; z++) chk("inv_roundtrip", got[z], orig[z]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
